// File: rtl/ofm_collector.sv
// Purpose : reassemble the write-back controller's dual-port OFM stream into c/h/w order and
//           issue linear-address writes to a two-write-port OFM memory; optional ReLU via OFM_COLLECT_RELU_EN.
// Latency : 1 cycle from accepted beat to wr_en*/wr_addr*/wr_data*; no backpressure, one beat per cycle.
module ofm_collector #(
    parameter int data_width = 25,
    parameter int addr_width = 10,
    parameter int ofm_c      = 1,
    parameter int ofm_h      = 10,
    parameter int ofm_w      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [data_width-1:0] in_port0,
    input  logic [data_width-1:0] in_port1,
    input  logic                  in_port0_valid,
    input  logic                  in_port1_valid,
    output logic                  wr_en0,
    output logic [addr_width-1:0] wr_addr0,
    output logic [data_width-1:0] wr_data0,
    output logic                  wr_en1,
    output logic [addr_width-1:0] wr_addr1,
    output logic [data_width-1:0] wr_data1,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    // Counter widths leave headroom for the post-increment values compared against the limits.
    localparam int CW = $clog2(ofm_c + 1);
    localparam int HW = $clog2(ofm_h + 2);
    localparam int WW = $clog2(ofm_w + 1);

    localparam logic [addr_width-1:0] L_ROW_STEP1 = addr_width'(ofm_w);
    localparam logic [addr_width-1:0] L_ROW_STEP2 = addr_width'(2 * ofm_w);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    logic [CW-1:0]         r_c;
    logic [HW-1:0]         r_h;
    logic [WW-1:0]         r_w;
    logic [addr_width-1:0] r_row_base;
    logic                  r_mode;      // 1 = current row is a dual row

    logic                  w_dual;
    logic                  w_beat;
    logic                  w_err_p1_only;
    logic                  w_err_last_row;
    logic                  w_err_mode;
    logic                  w_bad;
    logic                  w_accept;
    logic                  w_row_end;
    logic [HW-1:0]         w_h_inc;
    logic                  w_h_wrap;
    logic [CW-1:0]         w_c_inc;
    logic                  w_last;
    logic [addr_width-1:0] w_addr0;
    logic [addr_width-1:0] w_addr1;

    // ReLU clamps negative words to zero when enabled; otherwise words pass through untouched.
    function automatic logic [data_width-1:0] f_relu(input logic [data_width-1:0] d);
`ifdef OFM_COLLECT_RELU_EN
        return d[data_width-1] ? '0 : d;
`else
        return d;
`endif
    endfunction

    // Beat classification, protocol checks and counter arithmetic.
    always_comb begin
        w_dual         = in_port0_valid && in_port1_valid;
        w_beat         = (r_state == S_RUN) && !start && (in_port0_valid || in_port1_valid);
        w_err_p1_only  = in_port1_valid && !in_port0_valid;
        w_err_last_row = w_dual && (r_h == HW'(ofm_h - 1));
        w_err_mode     = in_port0_valid && (r_w != '0) && (w_dual != r_mode);
        w_bad          = w_err_p1_only || w_err_last_row || w_err_mode;
        w_accept       = w_beat && !w_bad;
        w_row_end      = (r_w == WW'(ofm_w - 1));
        w_h_inc        = r_h + (w_dual ? HW'(2) : HW'(1));
        w_h_wrap       = (w_h_inc >= HW'(ofm_h));
        w_c_inc        = r_c + CW'(1);
        w_last         = w_accept && w_row_end && w_h_wrap && (w_c_inc == CW'(ofm_c));
        w_addr0        = r_row_base + addr_width'(r_w);
        w_addr1        = w_addr0 + L_ROW_STEP1;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: start always (re)enters RUN; the last accepted word ends the map.
    always_comb begin
        w_state_next = r_state;
        if (start) begin
            w_state_next = S_RUN;
        end else if ((r_state == S_RUN) && w_last) begin
            w_state_next = S_DONE;
        end
    end

    // Status outputs decoded straight from the state flop.
    always_comb begin
        busy = (r_state == S_RUN);
        done = (r_state == S_DONE);
    end

    // Position counters; row_base tracks c*H*W + h*W incrementally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_c        <= '0;
            r_h        <= '0;
            r_w        <= '0;
            r_row_base <= '0;
            r_mode     <= 1'b0;
        end else if (start) begin
            r_c        <= '0;
            r_h        <= '0;
            r_w        <= '0;
            r_row_base <= '0;
            r_mode     <= 1'b0;
        end else if (w_accept) begin
            if (r_w == '0) begin
                r_mode <= w_dual;
            end
            if (w_row_end) begin
                r_w        <= '0;
                r_row_base <= r_row_base + (w_dual ? L_ROW_STEP2 : L_ROW_STEP1);
                if (w_h_wrap) begin
                    r_h <= '0;
                    r_c <= w_c_inc;
                end else begin
                    r_h <= w_h_inc;
                end
            end else begin
                r_w <= r_w + WW'(1);
            end
        end
    end

    // Registered memory write ports; address/data hold their last value between writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en0   <= 1'b0;
            wr_addr0 <= '0;
            wr_data0 <= '0;
            wr_en1   <= 1'b0;
            wr_addr1 <= '0;
            wr_data1 <= '0;
        end else begin
            wr_en0 <= w_accept;
            wr_en1 <= w_accept && w_dual;
            if (w_accept) begin
                wr_addr0 <= w_addr0;
                wr_data0 <= f_relu(in_port0);
            end
            if (w_accept && w_dual) begin
                wr_addr1 <= w_addr1;
                wr_data1 <= f_relu(in_port1);
            end
        end
    end

    // Sticky protocol-error flag; a start pulse clears it and its own beat is never judged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (start) begin
            err <= 1'b0;
        end else if (w_beat && w_bad) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ofm_collector.sv
// Directed bench for ofm_collector (C=1, H=10, W=8): dual, single and mixed streams,
// protocol errors, restart, DONE ignore, async reset and the optional ReLU.
// Inputs change 1 ns after a rising edge; outputs are sampled at the same point.
module tb_ofm_collector;

    localparam int DW = 25;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] in_port0 = '0;
    logic [DW-1:0] in_port1 = '0;
    logic          in_port0_valid = 1'b0;
    logic          in_port1_valid = 1'b0;
    logic          wr_en0, wr_en1, busy, done, err;
    logic [AW-1:0] wr_addr0, wr_addr1;
    logic [DW-1:0] wr_data0, wr_data1;

    int checks = 0;
    int errors = 0;

    // Write log filled by tick()
    logic [DW-1:0] log_dat [0:1023];
    bit            log_hit [0:1023];
    int            n0, n1;
    int            q0 [$];

    ofm_collector #(
        .data_width(DW), .addr_width(AW), .ofm_c(1), .ofm_h(10), .ofm_w(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_port0(in_port0), .in_port1(in_port1),
        .in_port0_valid(in_port0_valid), .in_port1_valid(in_port1_valid),
        .wr_en0(wr_en0), .wr_addr0(wr_addr0), .wr_data0(wr_data0),
        .wr_en1(wr_en1), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic clear_log();
        for (int i = 0; i < 1024; i++) begin
            log_hit[i] = 1'b0;
            log_dat[i] = '0;
        end
        n0 = 0;
        n1 = 0;
        q0.delete();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (wr_en0) begin
            log_dat[wr_addr0] = wr_data0;
            log_hit[wr_addr0] = 1'b1;
            n0++;
            q0.push_back(int'(wr_addr0));
        end
        if (wr_en1) begin
            log_dat[wr_addr1] = wr_data1;
            log_hit[wr_addr1] = 1'b1;
            n1++;
        end
    endtask

    task automatic drv(input logic v0, input logic v1, input int d0, input int d1);
        in_port0_valid = v0;
        in_port1_valid = v1;
        in_port0       = DW'(d0);
        in_port1       = DW'(d1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({wr_en0, wr_en1, wr_addr0, wr_addr1, wr_data0, wr_data1, busy, done, err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got en0=%0b en1=%0b a0=%0d a1=%0d d0=%h d1=%h busy=%0b done=%0b err=%0b, want all 0",
                     wr_en0, wr_en1, wr_addr0, wr_addr1, wr_data0, wr_data1, busy, done, err);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_dual_stream();
        int bad;
        bit done_early;
        clear_log();
        pulse_start();
        done_early = 1'b0;
        for (int r = 0; r < 5; r++) begin
            for (int w = 0; w < 8; w++) begin
                drv(1, 1, 2 * r * 8 + w, (2 * r + 1) * 8 + w);
                tick();
                if (!(r == 4 && w == 7) && done) done_early = 1'b1;
            end
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL dual_done_timing: done=%0b busy=%0b after beat 40, want done=1 busy=0", done, busy);
        end
        checks++;
        if (done_early !== 1'b0) begin
            errors++;
            $display("FAIL dual_done_early: done rose before beat 40, want it low until then");
        end
        drv(0, 0, 0, 0);
        tick();
        bad = 0;
        for (int a = 0; a < 80; a++) if (!log_hit[a] || log_dat[a] !== DW'(a)) bad++;
        checks++;
        if (n0 + n1 !== 80 || bad !== 0) begin
            errors++;
            $display("FAIL dual_writes: %0d writes, %0d bad addresses, want 80 writes and 0 bad", n0 + n1, bad);
        end
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL dual_err: err=%0b, want 0", err);
        end
    endtask

    task automatic test_single_stream();
        int bad;
        bit done_early;
        clear_log();
        pulse_start();
        done_early = 1'b0;
        for (int k = 0; k < 80; k++) begin
            drv(1, 0, k, 0);
            tick();
            if (k != 79 && done) done_early = 1'b1;
        end
        checks++;
        if (done !== 1'b1 || done_early !== 1'b0) begin
            errors++;
            $display("FAIL single_done: done=%0b early=%0b, want done=1 only after beat 80", done, done_early);
        end
        drv(0, 0, 0, 0);
        tick();
        bad = 0;
        for (int k = 0; k < 80; k++) if (k >= q0.size() || q0[k] != k || log_dat[k] !== DW'(k)) bad++;
        checks++;
        if (q0.size() !== 80 || bad !== 0) begin
            errors++;
            $display("FAIL single_order: %0d port0 writes, %0d out of order, want 80 in order", q0.size(), bad);
        end
        checks++;
        if (n1 !== 0) begin
            errors++;
            $display("FAIL single_port1: %0d port1 writes, want 0", n1);
        end
    endtask

    task automatic test_mixed_rows();
        int exp_rb [6] = '{0, 16, 32, 48, 64, 72};
        int got_rb [$];
        int h, beats, bad;
        clear_log();
        pulse_start();
        beats = 0;
        h = 0;
        for (int r = 0; r < 6; r++) begin
            for (int w = 0; w < 8; w++) begin
                if (r < 4) drv(1, 1, h * 8 + w, (h + 1) * 8 + w);
                else       drv(1, 0, h * 8 + w, 0);
                tick();
                beats++;
                if (w == 0) got_rb.push_back(int'(wr_addr0));
                if (beats < 48 && done) begin
                    checks++;
                    errors++;
                    $display("FAIL mixed_done_early: done high after beat %0d, want low before beat 48", beats);
                end
            end
            h += (r < 4) ? 2 : 1;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL mixed_done: done=%0b after beat 48, want 1", done);
        end
        bad = 0;
        for (int i = 0; i < 6; i++) if (got_rb[i] != exp_rb[i]) bad++;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL mixed_row_base: %0d row starts wrong (first %0d,%0d,%0d,%0d,%0d,%0d), want 0,16,32,48,64,72",
                     bad, got_rb[0], got_rb[1], got_rb[2], got_rb[3], got_rb[4], got_rb[5]);
        end
        drv(0, 0, 0, 0);
        tick();
        bad = 0;
        for (int a = 0; a < 80; a++) if (!log_hit[a] || log_dat[a] !== DW'(a)) bad++;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL mixed_contents: %0d bad addresses, want 0", bad);
        end
    endtask

    task automatic test_errors();
        pulse_start();
        for (int w = 0; w < 3; w++) begin
            drv(1, 0, w, 0);
            tick();
        end
        drv(0, 1, 0, 77);
        tick();
        checks++;
        if ({wr_en0, wr_en1} !== 2'b00 || err !== 1'b1) begin
            errors++;
            $display("FAIL err_p1_only: en0=%0b en1=%0b err=%0b, want 0 0 1", wr_en0, wr_en1, err);
        end
        drv(1, 0, 3, 0);
        tick();
        checks++;
        if (wr_en0 !== 1'b1 || wr_addr0 !== AW'(3)) begin
            errors++;
            $display("FAIL err_resume: en0=%0b addr0=%0d, want 1 and 3", wr_en0, wr_addr0);
        end
        for (int w = 4; w < 8; w++) begin
            drv(1, 0, w, 0);
            tick();
        end
        // row 1 latched single, then a dual beat mid-row must be dropped
        drv(1, 0, 8, 0);
        tick();
        drv(1, 1, 9, 17);
        tick();
        checks++;
        if ({wr_en0, wr_en1} !== 2'b00) begin
            errors++;
            $display("FAIL err_mode: en0=%0b en1=%0b, want both 0", wr_en0, wr_en1);
        end
        pulse_start();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: err=%0b after start, want 0", err);
        end
        for (int r = 0; r < 4; r++)
            for (int w = 0; w < 8; w++) begin
                drv(1, 1, 2 * r * 8 + w, (2 * r + 1) * 8 + w);
                tick();
            end
        for (int w = 0; w < 8; w++) begin
            drv(1, 0, 64 + w, 0);
            tick();
        end
        drv(1, 1, 72, 80);
        tick();
        checks++;
        if ({wr_en0, wr_en1} !== 2'b00 || err !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL err_last_row_dual: en0=%0b en1=%0b err=%0b busy=%0b, want 0 0 1 1",
                     wr_en0, wr_en1, err, busy);
        end
        for (int w = 0; w < 8; w++) begin
            drv(1, 0, 72 + w, 0);
            tick();
            if (w == 0) begin
                checks++;
                if (wr_en0 !== 1'b1 || wr_addr0 !== AW'(72)) begin
                    errors++;
                    $display("FAIL err_row9_addr: en0=%0b addr0=%0d, want 1 and 72", wr_en0, wr_addr0);
                end
            end
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL err_done: done=%0b, want 1", done);
        end
        drv(0, 0, 0, 0);
    endtask

    task automatic test_restart_ignore();
        int wr_seen;
        pulse_start();
        drv(1, 0, 0, 0); tick();
        drv(1, 0, 1, 0); tick();
        drv(0, 1, 0, 5); tick();
        for (int k = 2; k < 5; k++) begin
            drv(1, 0, k, 0);
            tick();
        end
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL restart_pre_err: err=%0b, want 1", err);
        end
        start = 1'b1;
        drv(1, 0, 99, 0);
        tick();
        start = 1'b0;
        checks++;
        if (wr_en0 !== 1'b0 || err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL restart_start_wins: en0=%0b err=%0b busy=%0b, want 0 0 1", wr_en0, err, busy);
        end
        drv(1, 0, 0, 0);
        tick();
        checks++;
        if (wr_en0 !== 1'b1 || wr_addr0 !== AW'(0) || wr_data0 !== DW'(0)) begin
            errors++;
            $display("FAIL restart_addr0: en0=%0b addr0=%0d, want 1 and 0", wr_en0, wr_addr0);
        end
        for (int k = 1; k < 80; k++) begin
            drv(1, 0, k, 0);
            tick();
        end
        wr_seen = 0;
        drv(1, 1, 5, 6); tick(); if (wr_en0 || wr_en1) wr_seen++;
        drv(0, 1, 0, 6); tick(); if (wr_en0 || wr_en1) wr_seen++;
        drv(1, 0, 7, 0); tick(); if (wr_en0 || wr_en1) wr_seen++;
        drv(0, 0, 0, 0); tick(); if (wr_en0 || wr_en1) wr_seen++;
        checks++;
        if (wr_seen !== 0 || err !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("FAIL done_ignore: %0d write cycles err=%0b done=%0b, want 0 0 1", wr_seen, err, done);
        end
    endtask

    task automatic test_async_reset();
        pulse_start();
        for (int k = 0; k < 3; k++) begin
            drv(1, 1, 100 + k, 200 + k);
            tick();
        end
        checks++;
        if (wr_en0 !== 1'b1 || wr_en1 !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_pre: en0=%0b en1=%0b busy=%0b, want 1 1 1", wr_en0, wr_en1, busy);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({wr_en0, wr_en1, wr_addr0, wr_addr1, wr_data0, wr_data1, busy, done, err} !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs: en0=%0b en1=%0b a0=%0d a1=%0d d0=%h d1=%h busy=%0b done=%0b, want all 0",
                     wr_en0, wr_en1, wr_addr0, wr_addr1, wr_data0, wr_data1, busy, done);
        end
        tick();
        rst_n = 1'b1;
        drv(1, 0, 1, 0);
        tick();
        checks++;
        if (wr_en0 !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_ignore: en0=%0b err=%0b busy=%0b, want 0 0 0", wr_en0, err, busy);
        end
        drv(0, 0, 0, 0);
    endtask

    task automatic test_relu();
        logic [DW-1:0] exp_neg;
`ifdef OFM_COLLECT_RELU_EN
        exp_neg = '0;
`else
        exp_neg = 25'h1FFFFFD;
`endif
        pulse_start();
        drv(1, 0, 0, 0);
        in_port0 = 25'h1FFFFFD;
        tick();
        checks++;
        if (wr_en0 !== 1'b1 || wr_data0 !== exp_neg) begin
            errors++;
            $display("FAIL relu_negative: en0=%0b data0=%h, want 1 and %h", wr_en0, wr_data0, exp_neg);
        end
        drv(1, 0, 25'h0ABCDE, 0);
        tick();
        checks++;
        if (wr_data0 !== 25'h0ABCDE || wr_addr0 !== AW'(1)) begin
            errors++;
            $display("FAIL relu_positive: data0=%h addr0=%0d, want 0abcde and 1", wr_data0, wr_addr0);
        end
        drv(0, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_dual_stream();
        test_single_stream();
        test_mixed_rows();
        test_errors();
        test_restart_ignore();
        test_async_reset();
        test_relu();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard stop in case a task loses the clock.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded 200000 ns, want completion");
        $fatal(1, "timeout");
    end

endmodule
